// File: rtl/mem_access_unit.sv
// MEM-stage access unit: maps MIPS byte/halfword/word loads and stores onto a
// word-wide data memory, using a two-cycle read-modify-write for sh/sb.
module mem_access_unit #(
  parameter int ADDR_LSB_HI = 11,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       op,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      dm_rdata,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_we,
  output logic [31:0]      load_data,
  output logic             stall,
  output logic             addr_err,
  output logic [CNT_W-1:0] rmw_count,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [31:0]      mergeQ;
  logic [CNT_W-1:0] rmwCountQ;

  logic        misalign;
  logic        outOfRange;
  logic        reqErr;
  logic        isRmw;
  logic        startRmw;
  logic        loadOk;
  logic [31:0] merged;
  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  assign dm_addr   = {addr[31:2], 2'b00};
  assign rmw_count = rmwCountQ;
  assign dbg_state = (state == WRITE);

  always_comb begin
    misalign = 1'b0;
    case (op)
      OP_LW, OP_SW:         misalign = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign = addr[0];
      default:              misalign = 1'b0;
    endcase
  end

  assign outOfRange = |addr[31:ADDR_LSB_HI+1];
  assign reqErr     = req_valid & (misalign | outOfRange);
  assign isRmw      = (op == OP_SH) || (op == OP_SB);
  assign startRmw   = reset & req_valid & ~reqErr & isRmw & (state == IDLE);
  assign loadOk     = reset & req_valid & ~reqErr & (state == IDLE);

  // Insert the store lane into the word just read; the rest of the word is kept.
  always_comb begin
    merged = dm_rdata;
    if (op == OP_SH) merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else             merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
  end

  assign halfSel = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  assign byteSel = dm_rdata[{addr[1:0], 3'b000} +: 8];

  always_comb begin
    load_data = 32'h0;
    if (loadOk) begin
      case (op)
        OP_LW:   load_data = dm_rdata;
        OP_LH:   load_data = {{16{halfSel[15]}}, halfSel};
        OP_LHU:  load_data = {16'h0, halfSel};
        OP_LB:   load_data = {{24{byteSel[7]}}, byteSel};
        OP_LBU:  load_data = {24'h0, byteSel};
        default: load_data = 32'h0;
      endcase
    end
  end

  // Handshake: stall is raised only in the read half of an RMW; dm_we only in
  // the write half or for sw, so the two never coincide.
  assign stall    = startRmw;
  assign addr_err = reset & reqErr;
  assign dm_we    = reset & req_valid &
                    ((state == WRITE) | ((state == IDLE) & ~reqErr & (op == OP_SW)));
  assign dm_wdata = (state == WRITE) ? mergeQ : wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mergeQ    <= 32'h0;
      rmwCountQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startRmw) begin
            mergeQ <= merged;
            state  <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
          if (req_valid && (rmwCountQ != '1)) rmwCountQ <= rmwCountQ + CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
